// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / hazard unit: tracker entry layout,
// stall FSM states and the "read from register file" select code.
package fwd_pkg;

  // Tracker entries hold the destination zero-extended to this width so the
  // struct stays independent of the instantiating module's AW (AW <= 8).
  localparam int FWD_RD_W = 8;

  // Select code meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                we;
    logic                load;
  } trk_entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator and priority encoder: finds the youngest in-flight
// producer of one source register and reports the forwarding select plus the
// number of stall cycles needed if that producer is a load not yet forwardable.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int AW         = 5,
  parameter int SELW       = 2
) (
  input  trk_entry_t       ent_i [NUM_STAGES],
  input  logic [AW-1:0]    rs_i,
  input  logic             used_i,
  output logic [SELW-1:0]  sel_o,
  output logic [SELW-1:0]  cyc_o
);

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    sel_o = SELW'(FWD_RF);
    cyc_o = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (used_i && ent_i[k].valid && ent_i[k].we &&
          (ent_i[k].rd != '0) && (ent_i[k].rd == FWD_RD_W'(rs_i))) begin
        sel_o = SELW'(k + 1);
        if (ent_i[k].load && (k < LOAD_LAT)) begin
          cyc_o = SELW'(LOAD_LAT - k);
        end else begin
          cyc_o = '0;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit. Tracks the destinations of the
// instructions downstream of decode, picks a forwarding source per operand,
// and stalls decode until a pending load result becomes forwardable.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int AW         = 5,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC*SELW-1:0]  ex_fwd_sel,
  output logic                     ex_valid,
  output logic [15:0]              stall_count
);

  trk_entry_t             trk_q [NUM_STAGES];
  trk_entry_t             ent_d;
  fsm_state_t             state_q, state_d;
  logic [SELW-1:0]        cnt_q, cnt_d;
  logic [NUM_SRC*SELW-1:0] ex_fwd_sel_q, ex_fwd_sel_d;
  logic                   ex_valid_q;
  logic [15:0]            stall_count_q;

  logic [SELW-1:0]        sel_w [NUM_SRC];
  logic [SELW-1:0]        cyc_w [NUM_SRC];
  logic [SELW-1:0]        need;
  logic                   issue;

  // One comparator/encoder per source operand; unused or invalid sources never match.
  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_match #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_LAT   (LOAD_LAT),
      .AW         (AW),
      .SELW       (SELW)
    ) u_match (
      .ent_i  (trk_q),
      .rs_i   (id_rs[j*AW +: AW]),
      .used_i (id_rs_used[j] & id_valid),
      .sel_o  (sel_w[j]),
      .cyc_o  (cyc_w[j])
    );
  end

  // Worst-case stall requirement over all sources, and the packed select bus.
  always_comb begin
    need         = '0;
    ex_fwd_sel_d = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (cyc_w[j] > need) need = cyc_w[j];
      ex_fwd_sel_d[j*SELW +: SELW] = sel_w[j];
    end
  end

  // Flush overrides everything; otherwise stall in STALL or on a fresh hazard.
  always_comb begin
    stall = rst_n && !flush && ((state_q == ST_STALL) || (need != '0));
    issue = id_valid && !stall && !flush;
    ent_d = '0;
    if (issue) begin
      ent_d.valid = 1'b1;
      ent_d.rd    = FWD_RD_W'(id_rd);
      ent_d.we    = id_regwrite;
      ent_d.load  = id_is_load;
    end
  end

  // Next-state logic of the RUN/STALL down-counter FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (need > SELW'(1)) begin
            state_d = ST_STALL;
            cnt_d   = need - SELW'(1);
          end
        end
        ST_STALL: begin
          cnt_d = cnt_q - SELW'(1);
          if (cnt_q == SELW'(1)) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Tracker shift register: new entry (or bubble) enters at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) trk_q[k] <= '0;
    end else begin
      trk_q[0] <= ent_d;
      for (int k = 1; k < NUM_STAGES; k++) trk_q[k] <= trk_q[k-1];
    end
  end

  // FSM state, EX-stage registered outputs and the saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      ex_fwd_sel_q  <= '0;
      ex_valid_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ex_fwd_sel_q  <= issue ? ex_fwd_sel_d : '0;
      ex_valid_q    <= issue;
      if (stall && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign ex_fwd_sel  = ex_fwd_sel_q;
  assign ex_valid    = ex_valid_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one instance with default parameters and
// one with NUM_STAGES=4, LOAD_LAT=3 for the multi-cycle load-use cases.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic        flush;

  logic        stall_a, ex_valid_a;
  logic [3:0]  ex_fwd_sel_a;
  logic [15:0] stall_count_a;
  logic        stall_b, ex_valid_b;
  logic [5:0]  ex_fwd_sel_b;
  logic [15:0] stall_count_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall_a),
    .ex_fwd_sel  (ex_fwd_sel_a),
    .ex_valid    (ex_valid_a),
    .stall_count (stall_count_a)
  );

  fwd_hazard_unit #(.NUM_STAGES(4), .LOAD_LAT(3)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall_b),
    .ex_fwd_sel  (ex_fwd_sel_b),
    .ex_valid    (ex_valid_b),
    .stall_count (stall_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = we;
    id_is_load  = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check("rst_stall",       32'(stall_a),       32'd0);
    check("rst_ex_valid",    32'(ex_valid_a),    32'd0);
    check("rst_ex_fwd_sel",  32'(ex_fwd_sel_a),  32'd0);
    check("rst_stall_count", 32'(stall_count_a), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // ALU writes r5, next instruction reads r5 in source 0.
    drive(1, 1, 2, 2'b11, 5, 1, 0);
    mid();  check("alu_prod_stall", 32'(stall_a), 32'd0);
    step();
    drive(1, 5, 2, 2'b11, 6, 1, 0);
    mid();  check("alu_use_stall", 32'(stall_a), 32'd0);
    step();
    check("alu_use_sel",   32'(ex_fwd_sel_a), 32'h1);
    check("alu_use_valid", 32'(ex_valid_a),   32'd1);

    // Load r3, next instruction reads r3 in source 1: one stall cycle.
    drive(1, 0, 0, 2'b00, 3, 1, 1);
    mid();  check("ld_prod_stall", 32'(stall_a), 32'd0);
    step();
    drive(1, 1, 3, 2'b11, 8, 1, 0);
    mid();  check("ld_use_stall", 32'(stall_a), 32'd1);
    step();
    check("ld_use_bubble",   32'(ex_valid_a),    32'd0);
    check("ld_use_count",    32'(stall_count_a), 32'd1);
    mid();  check("ld_use_release", 32'(stall_a), 32'd0);
    step();
    check("ld_use_sel",      32'(ex_fwd_sel_a),  32'h8);
    check("ld_use_valid",    32'(ex_valid_a),    32'd1);
    check("ld_use_count2",   32'(stall_count_a), 32'd1);

    // Load r4, consumer's source 1 matches but is not read.
    drive(1, 0, 0, 2'b00, 4, 1, 1);
    step();
    drive(1, 0, 4, 2'b01, 0, 0, 0);
    mid();  check("unused_stall", 32'(stall_a), 32'd0);
    step();
    check("unused_sel",   32'(ex_fwd_sel_a), 32'h0);
    check("unused_valid", 32'(ex_valid_a),   32'd1);

    // r0 is never forwarded; with r7 at entries 0 and 2 the youngest wins.
    drive(1, 0, 0, 2'b00, 0, 1, 0);
    step();
    drive(1, 0, 0, 2'b11, 7, 1, 0);
    step();
    check("r0_sel", 32'(ex_fwd_sel_a), 32'h0);
    drive(1, 0, 0, 2'b00, 9, 1, 0);
    step();
    drive(1, 0, 0, 2'b00, 7, 1, 0);
    step();
    drive(1, 7, 0, 2'b01, 0, 0, 0);
    mid();  check("young_stall", 32'(stall_a), 32'd0);
    step();
    check("young_sel", 32'(ex_fwd_sel_a), 32'h1);

    // id_valid low: inputs ignored even if they match a pending load.
    drive(1, 0, 0, 2'b00, 3, 1, 1);
    step();
    drive(0, 3, 3, 2'b11, 3, 1, 1);
    mid();  check("inv_stall", 32'(stall_a), 32'd0);
    step();
    check("inv_valid", 32'(ex_valid_a), 32'd0);

    // Second instance: clean start.
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // LOAD_LAT=3: load r9 then dependent read stalls three cycles.
    drive(1, 0, 0, 2'b00, 9, 1, 1);
    mid();  check("l3_prod_stall", 32'(stall_b), 32'd0);
    step();
    drive(1, 9, 0, 2'b01, 10, 1, 0);
    mid();  check("l3_stall1", 32'(stall_b), 32'd1);
    step();
    check("l3_bubble1", 32'(ex_valid_b), 32'd0);
    mid();  check("l3_stall2", 32'(stall_b), 32'd1);
    step();
    mid();  check("l3_stall3", 32'(stall_b), 32'd1);
    step();
    mid();  check("l3_release", 32'(stall_b), 32'd0);
    step();
    check("l3_sel",   32'(ex_fwd_sel_b),  32'h4);
    check("l3_valid", 32'(ex_valid_b),    32'd1);
    check("l3_count", 32'(stall_count_b), 32'd3);

    // Same hazard, flushed on the second stall cycle.
    drive(1, 0, 0, 2'b00, 11, 1, 1);
    step();
    drive(1, 11, 0, 2'b01, 13, 1, 0);
    mid();  check("fl_stall1", 32'(stall_b), 32'd1);
    step();
    flush = 1'b1;
    #1;
    check("fl_stall2", 32'(stall_b), 32'd0);
    step();
    check("fl_valid", 32'(ex_valid_b),    32'd0);
    check("fl_count", 32'(stall_count_b), 32'd4);
    flush = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    step();

    // Reset asserted while the FSM is in STALL.
    drive(1, 0, 0, 2'b00, 12, 1, 1);
    step();
    drive(1, 12, 0, 2'b01, 14, 1, 0);
    mid();  check("rs_stall1", 32'(stall_b), 32'd1);
    step();
    check("rs_in_stall", 32'(stall_b), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_stall",  32'(stall_b),       32'd0);
    check("rs_valid",  32'(ex_valid_b),    32'd0);
    check("rs_count",  32'(stall_count_b), 32'd0);
    check("rs_sel",    32'(ex_fwd_sel_b),  32'd0);
    mid();
    rst_n = 1'b1;
    #1;
    check("rs_after_stall", 32'(stall_b), 32'd0);
    step();
    check("rs_after_valid", 32'(ex_valid_b),   32'd1);
    check("rs_after_sel",   32'(ex_fwd_sel_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, source operands per instruction (1..4).
REQ-002 SHALL have parameter NUM_STAGES, default 3, downstream stages tracked for forwarding (2..6).
REQ-003 SHALL have parameter LOAD_LAT, default 1, first stage index at which load data is forwardable (0..NUM_STAGES-1).
REQ-004 SHALL have parameter AW, default 5, register address width; SELW = clog2(NUM_STAGES+1).
REQ-005 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port id_valid, input, 1, decode-stage instruction valid.
REQ-008 SHALL have port id_rs, input, NUM_SRC*AW, source register addresses, source j at bits [j*AW +: AW].
REQ-009 SHALL have port id_rs_used, input, NUM_SRC, per-source "operand read" flag; I-type rt cleared here.
REQ-010 SHALL have ports id_rd (AW), id_regwrite (1) and id_is_load (1), all inputs: destination, write enable and load flag.
REQ-011 SHALL have port flush, input, 1, kills the decode-stage instruction.
REQ-012 SHALL have port stall, output, 1, holds PC and IF/ID.
REQ-013 SHALL have port ex_fwd_sel, output, NUM_SRC*SELW, registered per-source mux select for EX; 0 = register file, k = stage k-1.
REQ-014 SHALL have port ex_valid, output, 1, registered; instruction in EX is real (not bubble).
REQ-015 SHALL have port stall_count, output, 16, saturating total of stall cycles.

Function
REQ-016 SHALL keep a tracker of NUM_STAGES entries {valid, rd, we, load}; every cycle entry[k] <= entry[k-1].
REQ-017 SHALL load entry[0] with the decode instruction when id_valid && !stall && !flush, else with a bubble (valid=0).
REQ-018 SHALL match source j at entry k when valid && we && rd != 0 && rd == rs_j && id_rs_used[j].
REQ-019 SHALL select the youngest matching entry (lowest k) per source; no match yields select 0.
REQ-020 SHALL flag a load-use hazard when the youngest match is a load with k < LOAD_LAT, needing LOAD_LAT-k stall cycles; multiple sources take the maximum.
REQ-021 SHALL implement FSM RUN/STALL with down-counter cnt; in RUN, a hazard asserts stall that cycle and, if cycles needed > 1, moves to STALL with cnt = cycles-1.
REQ-022 SHALL in STALL assert stall and decrement cnt, returning to RUN on the cycle cnt==1.
REQ-023 SHALL deassert stall in any cycle flush=1, return to RUN and clear cnt.
REQ-024 SHALL register ex_fwd_sel = selects and ex_valid = 1 on issue, else 0 and 0; latency exactly 1 cycle.
REQ-025 SHALL increment stall_count on every cycle stall=1, holding at 0xFFFF.
REQ-026 SHALL ignore id_* inputs when id_valid=0 (no stall, bubble issued).

Reset
REQ-027 SHALL on rst_n=0, asynchronously and regardless of state, clear all tracker entries, set FSM to RUN, cnt=0, ex_fwd_sel=0, ex_valid=0, stall_count=0; stall=0 throughout reset.

Structure
REQ-028 SHALL take from shared package fwd_pkg the tracker entry struct, FSM state enum and select encoding constant FWD_RF=0.
REQ-029 SHALL instantiate NUM_SRC copies of sub-module fwd_match (comparator and priority encoder, returns select and stall cycles).

Verification (defaults unless stated)
REQ-030 SHALL cover: ALU writes r5, next instruction reads rs0=r5 -> stall=0, next cycle ex_fwd_sel[0]=1, ex_valid=1.
REQ-031 SHALL cover: load to r3, next instruction reads rs1=r3 -> stall=1 one cycle, ex_valid=0, then ex_fwd_sel[1]=2, stall_count=1.
REQ-032 SHALL cover: write to r0 then read r0 -> ex_fwd_sel=0; write r7 at entries 0 and 2 -> select 1.
REQ-033 SHALL cover: LOAD_LAT=3, load r9 then dependent read -> stall 3 cycles; flush on 2nd stall cycle -> stall=0 that cycle, ex_valid=0 next.
REQ-034 SHALL cover: rst_n low during STALL -> stall, ex_valid, stall_count all 0 immediately; a read of that load's rd after release -> no stall.
REQ-035 SHALL cover: id_rs_used[1]=0 with rs1 matching a pending load -> no stall, ex_fwd_sel[1]=0.
